// File: rtl/oka_pkg.sv
// Shared definitions for the sequential overlap-free Karatsuba carry-less multiplier.
// Holds the controller state encoding, opcode values and a wide reference helper.
package oka_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL0 = 3'd1,
        MUL1 = 3'd2,
        MUL2 = 3'd3,
        DONE = 3'd4
    } oka_state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_SQR = 1'b1;

    localparam int REF_MAX_W = 256;

    function automatic int clmul_width(input int w);
        return 2 * w - 1;
    endfunction

    // Shift-and-xor product of two operands of up to REF_MAX_W coefficients.
    function automatic logic [2*REF_MAX_W-2:0] clmul_ref(input logic [REF_MAX_W-1:0] x,
                                                        input logic [REF_MAX_W-1:0] z);
        logic [2*REF_MAX_W-2:0] r;
        r = {(2*REF_MAX_W-1){1'b0}};
        for (int i = 0; i < REF_MAX_W; i++) begin
            if (x[i]) begin
                r = r ^ ({{(REF_MAX_W-1){1'b0}}, z} << i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/oka_clmul_comb.sv
// Purely combinational N x N -> 2N-1 carry-less (GF(2)[x]) schoolbook multiplier.
module oka_clmul_comb #(
    parameter int N = 66
) (
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   z,
    output logic [2*N-2:0] p
);

    // Accumulate every partial product x[i]&z[j] into coefficient i+j.
    always_comb begin
        p = {(2*N-1){1'b0}};
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                p[i+j] = p[i+j] ^ (x[i] & z[j]);
            end
        end
    end

endmodule

// File: rtl/oka_mul_seq.sv
// Sequential W-bit carry-less multiplier: one even/odd Karatsuba split, a single shared
// half-width sub-multiplier used over three cycles, plus a single-cycle squaring path.
module oka_mul_seq
    import oka_pkg::*;
#(
    parameter int W = 131
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-2:0] y
);

    localparam int H = (W + 1) / 2;

    oka_state_t     state_r;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [2*H-2:0] p0_r;
    logic [2*H-2:0] p2_r;
    logic [2*W-2:0] y_r;
    logic           out_valid_r;

    logic [2*H-1:0] a_pad_s;
    logic [2*H-1:0] b_pad_s;
    logic [H-1:0]   ae_s;
    logic [H-1:0]   ao_s;
    logic [H-1:0]   be_s;
    logic [H-1:0]   bo_s;
    logic [H-1:0]   mx_s;
    logic [H-1:0]   mz_s;
    logic [2*H-2:0] prod_s;
    logic [2*H-1:0] p0x_s;
    logic [2*H-1:0] p1x_s;
    logic [2*H-1:0] p2x_s;
    logic [2*H-1:0] p2sh_s;
    logic [4*H-1:0] y_full_s;
    logic [2*W-2:0] sqr_s;
    logic           unused_hi_s;

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign y         = y_r;

    // Even/odd coefficient split; the odd half gets a zero MSB when W is odd.
    always_comb begin
        a_pad_s = {(2*H){1'b0}};
        b_pad_s = {(2*H){1'b0}};
        a_pad_s[W-1:0] = a_r;
        b_pad_s[W-1:0] = b_r;
        for (int j = 0; j < H; j++) begin
            ae_s[j] = a_pad_s[2*j];
            ao_s[j] = a_pad_s[2*j+1];
            be_s[j] = b_pad_s[2*j];
            bo_s[j] = b_pad_s[2*j+1];
        end
    end

    // Route the operand pair for the sub-product owned by the current state.
    always_comb begin
        case (state_r)
            MUL0: begin
                mx_s = ae_s;
                mz_s = be_s;
            end
            MUL1: begin
                mx_s = ao_s;
                mz_s = bo_s;
            end
            MUL2: begin
                mx_s = ae_s ^ ao_s;
                mz_s = be_s ^ bo_s;
            end
            default: begin
                mx_s = {H{1'b0}};
                mz_s = {H{1'b0}};
            end
        endcase
    end

    oka_clmul_comb #(
        .N (H)
    ) u_clmul (
        .x (mx_s),
        .z (mz_s),
        .p (prod_s)
    );

    // Overlap-free recombination; P1 comes straight from the sub-multiplier in MUL2.
    always_comb begin
        p0x_s  = {1'b0, p0_r};
        p1x_s  = {1'b0, prod_s};
        p2x_s  = {1'b0, p2_r};
        p2sh_s = {p2_r, 1'b0};
        y_full_s = {(4*H){1'b0}};
        for (int k = 0; k < 2*H; k++) begin
            y_full_s[2*k]   = p0x_s[k] ^ p2sh_s[k];
            y_full_s[2*k+1] = p1x_s[k] ^ p0x_s[k] ^ p2x_s[k];
        end
    end

    // Bits above 2W-2 are mathematically zero and are dropped.
    assign unused_hi_s = ^y_full_s[4*H-1:2*W-1];

    // Squaring in GF(2)[x] just spreads coefficient i to position 2i.
    always_comb begin
        sqr_s = {(2*W-1){1'b0}};
        for (int i = 0; i < W; i++) begin
            sqr_s[2*i] = a[i];
        end
    end

    // Controller, operand capture, sub-product and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            p0_r        <= {(2*H-1){1'b0}};
            p2_r        <= {(2*H-1){1'b0}};
            y_r         <= {(2*W-1){1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r <= a;
                        b_r <= b;
                        if (op == OP_SQR) begin
                            y_r         <= sqr_s;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            state_r <= MUL0;
                        end
                    end
                end
                MUL0: begin
                    p0_r    <= prod_s;
                    state_r <= MUL1;
                end
                MUL1: begin
                    p2_r    <= prod_s;
                    state_r <= MUL2;
                end
                MUL2: begin
                    y_r         <= y_full_s[2*W-2:0];
                    out_valid_r <= 1'b1;
                    state_r     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oka_mul_seq.sv
// Self-checking bench: W=4, W=8 and W=131 instances against a bit-level product model.
module tb_oka_mul_seq;
    import oka_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         op_s = 1'b0;
    logic         out_ready_s = 1'b1;
    logic [130:0] a_s = {131{1'b0}};
    logic [130:0] b_s = {131{1'b0}};
    logic         iv4_s = 1'b0;
    logic         iv8_s = 1'b0;
    logic         iv131_s = 1'b0;

    logic         ir4_s, ov4_s, ir8_s, ov8_s, ir131_s, ov131_s;
    logic [6:0]   y4_s;
    logic [14:0]  y8_s;
    logic [260:0] y131_s;

    int           sel_s = 2;
    logic         cur_ready_s;
    logic         cur_valid_s;
    logic [260:0] cur_y_s;
    logic [260:0] last_y_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    oka_mul_seq #(.W(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(iv4_s), .in_ready(ir4_s), .op(op_s),
        .a(a_s[3:0]), .b(b_s[3:0]), .out_valid(ov4_s), .out_ready(out_ready_s), .y(y4_s)
    );
    oka_mul_seq #(.W(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv8_s), .in_ready(ir8_s), .op(op_s),
        .a(a_s[7:0]), .b(b_s[7:0]), .out_valid(ov8_s), .out_ready(out_ready_s), .y(y8_s)
    );
    oka_mul_seq #(.W(131)) u_w131 (
        .clk(clk), .rst(rst), .in_valid(iv131_s), .in_ready(ir131_s), .op(op_s),
        .a(a_s), .b(b_s), .out_valid(ov131_s), .out_ready(out_ready_s), .y(y131_s)
    );

    // Present the selected instance's outputs on common, zero-extended signals.
    always_comb begin
        cur_y_s = {261{1'b0}};
        case (sel_s)
            0: begin
                cur_ready_s = ir4_s;
                cur_valid_s = ov4_s;
                cur_y_s[6:0] = y4_s;
            end
            1: begin
                cur_ready_s = ir8_s;
                cur_valid_s = ov8_s;
                cur_y_s[14:0] = y8_s;
            end
            default: begin
                cur_ready_s = ir131_s;
                cur_valid_s = ov131_s;
                cur_y_s = y131_s;
            end
        endcase
    end

    function automatic int width_of(input int sel);
        case (sel)
            0:       return 4;
            1:       return 8;
            default: return 131;
        endcase
    endfunction

    // Reference: textbook polynomial product over GF(2), or squaring by definition.
    function automatic logic [260:0] ref_model(input int w, input logic opm,
                                               input logic [130:0] x, input logic [130:0] z);
        logic [260:0] r;
        r = {261{1'b0}};
        for (int i = 0; i < w; i++) begin
            if (opm == OP_SQR) begin
                r[2*i] = x[i];
            end else begin
                for (int j = 0; j < w; j++) begin
                    r[i+j] = r[i+j] ^ (x[i] & z[j]);
                end
            end
        end
        return r;
    endfunction

    function automatic logic [130:0] rand_operand(input int w);
        logic [159:0] raw;
        logic [130:0] r;
        raw = {$urandom, $urandom, $urandom, $urandom, $urandom};
        r = raw[130:0];
        if ($urandom_range(0, 7) == 0) r = {131{1'b1}};
        for (int i = w; i < 131; i++) r[i] = 1'b0;
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [260:0] got, input logic [260:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (W=%0d): got %h expected %h", tag, width_of(sel_s), got, exp);
        end
    endtask

    task automatic set_iv(input int sel, input logic v);
        iv4_s   = (sel == 0) ? v : 1'b0;
        iv8_s   = (sel == 1) ? v : 1'b0;
        iv131_s = (sel == 2) ? v : 1'b0;
    endtask

    // mode 0: out_ready always 1; 1: random out_ready; 2: stall 5 cycles with ignored in_valid.
    task automatic run_op(input int sel, input logic opv, input logic [130:0] av,
                          input logic [130:0] bv, input int mode);
        logic [260:0] exp_y;
        logic [260:0] got_y;
        int  lat;
        int  hold;
        bit  ok;
        exp_y = ref_model(width_of(sel), opv, av, bv);
        @(posedge clk); #1;
        sel_s = sel; op_s = opv; a_s = av; b_s = bv; set_iv(sel, 1'b1);
        out_ready_s = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (cur_ready_s) begin ok = 1'b1; break; end
        end
        check_eq("accept", 261'(ok), 261'(1));
        if (!ok) begin set_iv(sel, 1'b0); return; end
        @(posedge clk); #1;
        set_iv(sel, 1'b0);
        a_s = rand_operand(131); b_s = rand_operand(131); op_s = ~opv;
        ok = 1'b0; lat = 0;
        for (int t = 0; t < 20; t++) begin
            lat++;
            @(negedge clk);
            if (cur_valid_s) begin ok = 1'b1; break; end
            @(posedge clk); #1;
            if (mode == 1) out_ready_s = 1'($urandom_range(0, 1));
        end
        check_eq("valid_seen", 261'(ok), 261'(1));
        if (!ok) return;
        check_eq("latency", 261'(lat), (opv == OP_SQR) ? 261'(1) : 261'(4));
        check_eq("y", cur_y_s, exp_y);
        got_y = cur_y_s;
        last_y_s = got_y;
        hold = (mode == 2) ? 5 : 0;
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (out_ready_s) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (mode == 2) begin
                hold--;
                if (hold <= 0) begin
                    out_ready_s = 1'b1; set_iv(sel, 1'b0);
                end else begin
                    set_iv(sel, 1'b1); a_s = rand_operand(131); op_s = 1'($urandom_range(0, 1));
                end
            end else begin
                out_ready_s = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            check_eq("hold_valid", 261'(cur_valid_s), 261'(1));
            check_eq("hold_ready", 261'(cur_ready_s), 261'(0));
            check_eq("hold_y", cur_y_s, got_y);
        end
        check_eq("drained", 261'(ok), 261'(1));
        @(negedge clk);
        check_eq("post_valid", 261'(cur_valid_s), 261'(0));
        check_eq("post_ready", 261'(cur_ready_s), 261'(1));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [260:0] e;
        logic [130:0] ones;
        int w;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel_s = s; #1;
            check_eq("rst_ready", 261'(cur_ready_s), 261'(1));
            check_eq("rst_valid", 261'(cur_valid_s), 261'(0));
            check_eq("rst_y", cur_y_s, 261'(0));
        end
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(0, OP_MUL, 131'(4'b1011), 131'(4'b0111), 0);
        check_eq("w4_mul_const", last_y_s, 261'(7'b0110001));
        run_op(0, OP_SQR, 131'(4'b1011), 131'(4'hF), 0);
        check_eq("w4_sqr_const", last_y_s, 261'(7'b1000101));

        ones = {131{1'b1}};
        run_op(2, OP_MUL, ones, 131'(1), 0);
        e = {261{1'b0}}; e[130:0] = ones;
        check_eq("w131_ones_x1", last_y_s, e);
        run_op(2, OP_MUL, 131'(1) << 130, 131'(1) << 130, 0);
        check_eq("w131_top_sq", last_y_s, 261'(1) << 260);

        run_op(2, OP_MUL, rand_operand(131), rand_operand(131), 2);

        // Reset asserted while the W=131 instance is in its second multiply cycle.
        @(posedge clk); #1;
        sel_s = 2; op_s = OP_MUL; a_s = rand_operand(131); b_s = rand_operand(131);
        set_iv(2, 1'b1); out_ready_s = 1'b1;
        @(negedge clk);
        check_eq("mr_idle", 261'(cur_ready_s), 261'(1));
        @(posedge clk); #1;
        set_iv(2, 1'b0);
        @(posedge clk); #1;
        check_eq("mr_busy", 261'(cur_ready_s), 261'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("mr_valid", 261'(cur_valid_s), 261'(0));
        check_eq("mr_y", cur_y_s, 261'(0));
        check_eq("mr_ready", 261'(cur_ready_s), 261'(1));
        run_op(2, OP_MUL, rand_operand(131), rand_operand(131), 0);

        for (int s = 0; s < 3; s++) begin
            w = width_of(s);
            for (int n = 0; n < ((s == 0) ? 100 : 400); n++) begin
                run_op(s, 1'($urandom_range(0, 1)), rand_operand(w), rand_operand(w), 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
